store_v_writer: RTL and testbench

Vector store engine; the write-side counterpart of the tile vector loader. Accepts a store command (DRAM byte address and element count), pulls fixed-width tiles from the datapath over a ready/valid handshake, and writes them to the DRAM model one byte per cycle. Elements past `length` in the final tile are not written. It sits between the accelerator result buffers and the shared `simple_memory` DRAM model.

---
 rtl/vec_mem_pkg.sv | 24 ++
 rtl/simple_memory.sv | 28 ++
 rtl/store_v_writer.sv | 138 +++++++++++++
 tb/tb_store_v_writer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// vec_mem_pkg : shared widths, store-engine state type and tile helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package vec_mem_pkg;

  localparam int DRAM_ADDR_W = 24;
  localparam int VLEN_W      = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TILE = 2'd1,
    WRITING   = 2'd2,
    DONE      = 2'd3
  } store_state_t;

  function automatic int elem_count(input int tile_w, input int data_w);
    return tile_w / data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/simple_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// simple_memory : single-port byte DRAM model, synchronous write and read
// Rev 1.0
// ---------------------------------------------------------------------------
module simple_memory #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= din;
    end
    dout <= r_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/store_v_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// store_v_writer : pulls tiles over ready/valid and writes them to DRAM bytewise
// Rev 1.0
// ---------------------------------------------------------------------------
module store_v_writer
  import vec_mem_pkg::*;
#(
  parameter  int TILE_WIDTH = 256,
  parameter  int DATA_WIDTH = 8,
  localparam int ELEM_COUNT = elem_count(TILE_WIDTH, DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [DRAM_ADDR_W-1:0] dram_addr,
  input  logic [VLEN_W-1:0]      length,
  input  logic [DATA_WIDTH-1:0]  tile_in [ELEM_COUNT],
  input  logic                   tile_valid,
  output logic                   tile_ready,
  output logic                   valid_out,
  output logic                   busy,
  input  logic [DRAM_ADDR_W-1:0] dbg_addr,
  output logic [7:0]             dbg_data
);

  localparam int                c_idx_w    = (ELEM_COUNT > 1) ? $clog2(ELEM_COUNT) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(ELEM_COUNT - 1);

  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $fatal(1, "store_v_writer: DATA_WIDTH must be 8");
  end

  store_state_t           r_state;
  logic [DRAM_ADDR_W-1:0] r_ptr;
  logic [VLEN_W-1:0]      r_len_q;
  logic [VLEN_W-1:0]      r_cnt;
  logic [c_idx_w-1:0]     r_idx;
  logic [7:0]             r_buf [ELEM_COUNT];
  logic                   mem_we;
  logic [DRAM_ADDR_W-1:0] mem_addr;
  logic [7:0]             mem_din;
  logic [c_idx_w-1:0]     w_next_idx;
  logic [DRAM_ADDR_W-1:0] w_ram_addr;

  assign w_next_idx = r_idx + c_idx_w'(1);
  assign busy       = (r_state != IDLE);
  // Backdoor reads bypass the address register so dbg_data has one-cycle latency.
  assign w_ram_addr = (r_state == IDLE) ? dbg_addr : mem_addr;

  // The bus always carries the element at r_idx; r_cnt counts writes issued so far.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      tile_ready <= 1'b0;
      valid_out  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      r_ptr      <= '0;
      r_len_q    <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      for (int i = 0; i < ELEM_COUNT; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      valid_out <= 1'b0;
      mem_we    <= 1'b0;
      case (r_state)
        IDLE: begin
          mem_addr <= dbg_addr;
          if (valid_in) begin
            r_ptr   <= dram_addr;
            r_len_q <= length;
            r_cnt   <= '0;
            if (length == '0) begin
              valid_out <= 1'b1;
              r_state   <= DONE;
            end else begin
              tile_ready <= 1'b1;
              r_state    <= WAIT_TILE;
            end
          end
        end
        WAIT_TILE: begin
          if (tile_valid && tile_ready) begin
            r_buf      <= tile_in;
            tile_ready <= 1'b0;
            r_idx      <= '0;
            mem_we     <= 1'b1;
            mem_addr   <= r_ptr;
            mem_din    <= tile_in[0];
            r_ptr      <= r_ptr + 24'd1;
            r_cnt      <= r_cnt + 10'd1;
            r_state    <= WRITING;
          end
        end
        WRITING: begin
          if (r_cnt == r_len_q) begin
            valid_out <= 1'b1;
            r_state   <= DONE;
          end else if (r_idx == c_last_idx) begin
            tile_ready <= 1'b1;
            r_state    <= WAIT_TILE;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= r_ptr;
            mem_din  <= r_buf[w_next_idx];
            r_ptr    <= r_ptr + 24'd1;
            r_idx    <= w_next_idx;
            r_cnt    <= r_cnt + 10'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  simple_memory #(
    .ADDR_WIDTH(DRAM_ADDR_W),
    .DATA_WIDTH(8)
  ) u_mem (
    .clk (clk),
    .we  (mem_we),
    .addr(w_ram_addr),
    .din (mem_din),
    .dout(dbg_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_store_v_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_store_v_writer : randomized scoreboard bench for the vector store engine
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_store_v_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [23:0] dram_addr;
  logic [9:0]  length;
  logic [7:0]  tile_in [32];
  logic        tile_valid;
  logic        tile_ready;
  logic        valid_out;
  logic        busy;
  logic [23:0] dbg_addr;
  logic [7:0]  dbg_data;

  store_v_writer dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .dram_addr (dram_addr),
    .length    (length),
    .tile_in   (tile_in),
    .tile_valid(tile_valid),
    .tile_ready(tile_ready),
    .valid_out (valid_out),
    .busy      (busy),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        wq [$];
  int         done_q [$];
  logic [7:0] ref_mem [logic [23:0]];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         nwr      = 0;
  int         done_cnt = 0;
  wr_t        mw;
  int         md;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every DRAM write and every completion is matched to the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (dut.mem_we) begin
        check("write_pending", 64'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          mw = wq.pop_front();
          check("wr_addr", dut.mem_addr, mw.a);
          check("wr_data", dut.mem_din, mw.d);
          ref_mem[mw.a] = mw.d;
          nwr++;
        end
      end
      if (valid_out) begin
        check("done_pending", 64'(done_q.size() > 0), 1);
        if (done_q.size() > 0) begin
          md = done_q.pop_front();
          check("done_cycle", cyc, md);
          check("done_writes_left", wq.size(), 0);
        end
        done_cnt++;
      end
    end
  end

  // mode 0: random bytes, 1: element i of each tile is i+1, 2: all 0xEE.
  task automatic do_cmd(input logic [23:0] a, input int len, input int mode,
                        input int gap, input bit repulse);
    logic [7:0] data [];
    int ntiles, exp_done, k, acc, n, d0;
    ntiles = (len + 31) / 32;
    data   = new[ntiles * 32];
    for (int e = 0; e < ntiles * 32; e++) begin
      data[e] = (mode == 0) ? 8'($urandom) : (mode == 1) ? 8'(e % 32 + 1) : 8'hEE;
    end
    for (int e = 0; e < len; e++) begin
      wq.push_back('{a: a + 24'(e), d: data[e]});
    end
    exp_done = 0;
    for (int t = 0; t < ntiles; t++) begin
      k = (len - 32 * t > 32) ? 32 : len - 32 * t;
      exp_done += gap + 1 + k;
    end
    d0        = done_cnt;
    valid_in  = 1'b1;
    dram_addr = a;
    length    = 10'(len);
    @(posedge clk); #1;
    valid_in = 1'b0;
    acc = cyc;
    done_q.push_back(acc + exp_done);
    check("accept_busy", busy, 1);
    check("accept_ready", tile_ready, 64'(len != 0));
    for (int t = 0; t < ntiles; t++) begin
      n = 0;
      while (!tile_ready && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 200) begin
        check("tile_ready_timeout", 0, 1);
        return;
      end
      tile_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        if (repulse && t == 0 && g == 1) begin
          valid_in  = 1'b1;
          dram_addr = 24'h700;
          length    = 10'd7;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("gap_ready", tile_ready, 1);
        check("gap_no_write", dut.mem_we, 0);
      end
      for (int i = 0; i < 32; i++) tile_in[i] = data[t * 32 + i];
      tile_valid = 1'b1;
      @(posedge clk); #1;
      // Junk held valid while writing must be ignored.
      for (int i = 0; i < 32; i++) tile_in[i] = 8'($urandom);
      tile_valid = 1'b1;
    end
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    tile_valid = 1'b0;
    if (n >= 300) check("done_timeout", 0, 1);
    check("idle_busy", busy, 0);
  endtask

  task automatic dbg_read(input logic [23:0] a, input logic [7:0] exp, input string nm);
    dbg_addr = a;
    @(posedge clk); #1;
    check(nm, dbg_data, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ra;
    logic [7:0]  rdata [32];
    int          base, n, rlen, rgap;
    rst        = 1'b1;
    valid_in   = 1'b0;
    dram_addr  = '0;
    length     = '0;
    tile_valid = 1'b0;
    dbg_addr   = '0;
    for (int i = 0; i < 32; i++) tile_in[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tile_ready", tile_ready, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_we", dut.mem_we, 0);
    check("rst_mem_addr", dut.mem_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_cmd(24'h000100, 32, 1, 0, 1'b0);
    dbg_read(24'h00011F, 8'h20, "bd_0x11f");
    dbg_read(24'h000100, 8'h01, "bd_0x100");

    do_cmd(24'h000200, 64, 2, 0, 1'b0);
    do_cmd(24'h000200, 40, 0, 0, 1'b0);
    dbg_read(24'h000228, 8'hEE, "bd_0x228_kept");
    dbg_read(24'h00023F, 8'hEE, "bd_0x23f_kept");
    dbg_read(24'h000227, ref_mem[24'h000227], "bd_0x227");

    do_cmd(24'h000123, 0, 0, 0, 1'b0);

    do_cmd(24'hFFFFF0, 32, 0, 0, 1'b0);
    dbg_read(24'hFFFFFF, ref_mem[24'hFFFFFF], "bd_wrap_top");
    dbg_read(24'h00000F, ref_mem[24'h00000F], "bd_wrap_low");

    do_cmd(24'h000400, 32, 0, 5, 1'b1);

    // Reset in the middle of a store.
    base = nwr;
    for (int e = 0; e < 32; e++) begin
      rdata[e] = 8'($urandom);
      wq.push_back('{a: 24'h300 + 24'(e), d: rdata[e]});
    end
    valid_in  = 1'b1;
    dram_addr = 24'h000300;
    length    = 10'd32;
    @(posedge clk); #1;
    valid_in = 1'b0;
    for (int i = 0; i < 32; i++) tile_in[i] = rdata[i];
    tile_valid = 1'b1;
    @(posedge clk); #1;
    tile_valid = 1'b0;
    n = 0;
    while (nwr < base + 10 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_progress", nwr - base, 10);
    rst = 1'b1;
    #1;
    check("abort_mem_we", dut.mem_we, 0);
    check("abort_tile_ready", tile_ready, 0);
    check("abort_valid_out", valid_out, 0);
    check("abort_busy", busy, 0);
    wq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dbg_read(24'h000309, rdata[9], "bd_pre_abort");
    do_cmd(24'h000300, 32, 0, 0, 1'b0);
    dbg_read(24'h00031F, ref_mem[24'h00031F], "bd_after_abort");

    for (int r = 0; r < 6; r++) begin
      ra   = 24'($urandom);
      rlen = $urandom_range(1, 100);
      rgap = $urandom_range(0, 3);
      do_cmd(ra, rlen, 0, rgap, (r % 2) == 1);
      dbg_read(ra + 24'(rlen - 1), ref_mem[ra + 24'(rlen - 1)], "bd_random_last");
      dbg_read(ra, ref_mem[ra], "bd_random_first");
    end

    check("queue_drained", wq.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
